lpc_mem_arbiter: RTL and testbench

Shares the single LPC host between the risc16 core's instruction-fetch port and data-memory port. Each 16-bit word request becomes two sequenced LPC byte cycles, low byte first. The block drives the LPC host's go/dir/addr/write_data controls, reassembles read data and returns a one-cycle acknowledge to the granted requester. It sits between the core and the lpc instance in the top level.

---
 rtl/lpc_arb_pkg.sv | 31 +++
 rtl/lpc_mem_arbiter_if.sv | 41 ++++
 rtl/lpc_arb_pick.sv | 31 +++
 rtl/lpc_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_lpc_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lpc_arb_pkg.sv
// Shared types and constants for the LPC memory arbiter.
package lpc_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_LO = 3'd1,
        WAIT_LO  = 3'd2,
        ISSUE_HI = 3'd3,
        WAIT_HI  = 3'd4,
        RESP     = 3'd5
    } state_t;

    typedef enum logic {
        REQ_IMEM = 1'b0,
        REQ_DMEM = 1'b1
    } req_id_t;

    localparam logic LPC_DIR_READ  = 1'b0;
    localparam logic LPC_DIR_WRITE = 1'b1;

    localparam logic BEAT_LO = 1'b0;
    localparam logic BEAT_HI = 1'b1;

    // Byte address of one beat of a 16-bit word; wraps modulo 2^32.
    function automatic logic [31:0] byte_addr(input logic [31:0] base,
                                              input logic [15:0] word_addr,
                                              input logic        beat);
        return base + {15'd0, word_addr, 1'b0} + {31'd0, beat};
    endfunction

endpackage

// File: rtl/lpc_mem_arbiter_if.sv
// Requester and LPC-host signal bundle for lpc_mem_arbiter.
// slave: the arbiter's view. master: the surrounding core/host view.
interface lpc_mem_arbiter_if;

    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;

    logic        lpc_go;
    logic        lpc_dir;
    logic [31:0] lpc_addr;
    logic [7:0]  lpc_wdata;
    logic        lpc_busy;
    logic        lpc_done;
    logic [7:0]  lpc_rdata;

    logic        arb_busy;

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  lpc_busy, lpc_done, lpc_rdata,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata,
        output lpc_go, lpc_dir, lpc_addr, lpc_wdata, arb_busy
    );

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output lpc_busy, lpc_done, lpc_rdata,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata,
        input  lpc_go, lpc_dir, lpc_addr, lpc_wdata, arb_busy
    );

endinterface

// File: rtl/lpc_arb_pick.sv
// Grant selection between the fetch and data requesters.
// LPC_ARB_RR_EN: round-robin on ties using the last-granted pointer;
// otherwise dmem always wins a tie and no pointer input exists.
import lpc_arb_pkg::*;

module lpc_arb_pick (
    input  logic    imem_req,
    input  logic    dmem_req,
`ifdef LPC_ARB_RR_EN
    input  req_id_t last,
`endif
    output logic    grant,
    output req_id_t grant_id
);

    // Pick the winner; grant_id is only meaningful while grant is high.
    always_comb begin
        grant    = imem_req | dmem_req;
        grant_id = REQ_IMEM;
`ifdef LPC_ARB_RR_EN
        if (imem_req && dmem_req)
            grant_id = (last == REQ_IMEM) ? REQ_DMEM : REQ_IMEM;
        else if (dmem_req)
            grant_id = REQ_DMEM;
`else
        if (dmem_req)
            grant_id = REQ_DMEM;
`endif
    end

endmodule

// File: rtl/lpc_mem_arbiter.sv
// Shares one LPC host between the fetch and data ports of the core.
// Each 16-bit word becomes two LPC byte cycles, low byte first.
// Optional macro LPC_ARB_RR_EN selects round-robin tie breaking.
import lpc_arb_pkg::*;

module lpc_mem_arbiter #(
    parameter logic [31:0] IMEM_BASE = 32'h0000_0000,
    parameter logic [31:0] DMEM_BASE = 32'h0001_0000
) (
    input logic               clk,
    input logic               rst_n,
    lpc_mem_arbiter_if.slave  bus
);

    state_t      state, state_nxt;
    req_id_t     id_q;
    logic        dir_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [7:0]  lo_q;
    logic [15:0] imem_rdata_q;
    logic [15:0] dmem_rdata_q;

    logic        grant;
    req_id_t     grant_id;
    logic        in_beat;
    logic        beat;
    logic [31:0] base;

`ifdef LPC_ARB_RR_EN
    req_id_t     last_q;

    // Remember who was granted last; reset favours dmem on the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n)
            last_q <= REQ_IMEM;
        else if (state == IDLE && grant)
            last_q <= grant_id;
    end
`endif

    lpc_arb_pick u_pick (
        .imem_req (bus.imem_req),
        .dmem_req (bus.dmem_req),
`ifdef LPC_ARB_RR_EN
        .last     (last_q),
`endif
        .grant    (grant),
        .grant_id (grant_id)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Capture the granted request, collect read bytes, publish read words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_q         <= REQ_IMEM;
            dir_q        <= LPC_DIR_READ;
            addr_q       <= '0;
            wdata_q      <= '0;
            lo_q         <= '0;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
        end else begin
            if (state == IDLE && grant) begin
                id_q <= grant_id;
                if (grant_id == REQ_DMEM) begin
                    dir_q   <= bus.dmem_we ? LPC_DIR_WRITE : LPC_DIR_READ;
                    addr_q  <= bus.dmem_addr;
                    wdata_q <= bus.dmem_wdata;
                end else begin
                    dir_q   <= LPC_DIR_READ;
                    addr_q  <= bus.imem_addr;
                    wdata_q <= '0;
                end
            end
            if (state == WAIT_LO && bus.lpc_done)
                lo_q <= bus.lpc_rdata;
            // The word lands as RESP is entered, so it is valid with ack.
            if (state == WAIT_HI && bus.lpc_done) begin
                if (id_q == REQ_IMEM)
                    imem_rdata_q <= {bus.lpc_rdata, lo_q};
                else if (dir_q == LPC_DIR_READ)
                    dmem_rdata_q <= {bus.lpc_rdata, lo_q};
            end
        end
    end

    // Next state, go pulse and acknowledges.
    always_comb begin
        state_nxt    = state;
        bus.lpc_go   = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        case (state)
            IDLE:     if (grant) state_nxt = ISSUE_LO;
            ISSUE_LO: if (!bus.lpc_busy) begin
                          bus.lpc_go = 1'b1;
                          state_nxt  = WAIT_LO;
                      end
            WAIT_LO:  if (bus.lpc_done) state_nxt = ISSUE_HI;
            ISSUE_HI: if (!bus.lpc_busy) begin
                          bus.lpc_go = 1'b1;
                          state_nxt  = WAIT_HI;
                      end
            WAIT_HI:  if (bus.lpc_done) state_nxt = RESP;
            RESP: begin
                bus.imem_ack = (id_q == REQ_IMEM);
                bus.dmem_ack = (id_q == REQ_DMEM);
                state_nxt    = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // LPC controls are held from go until done and forced to 0 otherwise.
    always_comb begin
        in_beat       = (state == ISSUE_LO) || (state == WAIT_LO) ||
                        (state == ISSUE_HI) || (state == WAIT_HI);
        beat          = ((state == ISSUE_HI) || (state == WAIT_HI)) ? BEAT_HI : BEAT_LO;
        base          = (id_q == REQ_DMEM) ? DMEM_BASE : IMEM_BASE;
        bus.lpc_addr  = '0;
        bus.lpc_wdata = '0;
        bus.lpc_dir   = LPC_DIR_READ;
        if (in_beat) begin
            bus.lpc_addr  = byte_addr(base, addr_q, beat);
            bus.lpc_wdata = (beat == BEAT_HI) ? wdata_q[15:8] : wdata_q[7:0];
            bus.lpc_dir   = dir_q;
        end
    end

    assign bus.imem_rdata = imem_rdata_q;
    assign bus.dmem_rdata = dmem_rdata_q;
    assign bus.arb_busy   = (state != IDLE);

endmodule

// File: tb/tb_lpc_mem_arbiter.sv
// Directed bench for lpc_mem_arbiter with a small LPC host model.
// Builds with or without LPC_ARB_RR_EN; the tie-break expectations follow.
module tb_lpc_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    lpc_mem_arbiter_if m();
    lpc_mem_arbiter_if w();

    lpc_mem_arbiter #(.IMEM_BASE(32'h0000_0000), .DMEM_BASE(32'h0001_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(m)
    );

    lpc_mem_arbiter #(.IMEM_BASE(32'h0000_0000), .DMEM_BASE(32'hFFFF_FFFE)) u_wrap (
        .clk(clk), .rst_n(rst_n), .bus(w)
    );

    // Host model: done comes 3 cycles after go, busy in between.
    logic       force_busy = 1'b0;
    logic       force_done = 1'b0;
    logic       mdl_busy = 1'b0;
    logic       mdl_done = 1'b0;
    logic [7:0] mdl_rdata = 8'h00;
    int         mdl_cnt = 0;
    logic [7:0] rq[$];

    assign m.lpc_busy  = force_busy | mdl_busy;
    assign m.lpc_done  = force_done | mdl_done;
    assign m.lpc_rdata = mdl_rdata;

    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (!rst_n) begin
            mdl_cnt  <= 0;
            mdl_busy <= 1'b0;
        end else if (m.lpc_go) begin
            mdl_cnt  <= 1;
            mdl_busy <= 1'b1;
        end else if (mdl_cnt == 2) begin
            mdl_cnt   <= 0;
            mdl_busy  <= 1'b0;
            mdl_done  <= 1'b1;
            mdl_rdata <= (rq.size() > 0) ? rq.pop_front() : 8'h00;
        end else if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt + 1;
        end
    end

    // Second host: done the cycle after go, never busy.
    logic w_done = 1'b0;
    always @(posedge clk) w_done <= rst_n ? w.lpc_go : 1'b0;
    assign w.lpc_done  = w_done;
    assign w.lpc_busy  = 1'b0;
    assign w.lpc_rdata = 8'h00;

    // Monitor: record go pulses, count acks, watch addr/wdata stability.
    logic [31:0] go_addr[$];
    logic [7:0]  go_wd[$];
    logic        go_dir[$];
    int          go_cyc[$];
    int          n_iack = 0;
    int          n_dack = 0;
    int          stab_err = 0;
    logic        in_cyc = 1'b0;
    logic [31:0] lat_addr = '0;
    logic [7:0]  lat_wd = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_cyc <= 1'b0;
        end else if (m.lpc_go) begin
            go_addr.push_back(m.lpc_addr);
            go_wd.push_back(m.lpc_wdata);
            go_dir.push_back(m.lpc_dir);
            go_cyc.push_back(cyc);
            in_cyc   <= 1'b1;
            lat_addr <= m.lpc_addr;
            lat_wd   <= m.lpc_wdata;
        end else if (in_cyc) begin
            if (m.lpc_addr !== lat_addr || m.lpc_wdata !== lat_wd)
                stab_err <= stab_err + 1;
            if (m.lpc_done)
                in_cyc <= 1'b0;
        end
        if (m.imem_ack) n_iack <= n_iack + 1;
        if (m.dmem_ack) n_dack <= n_dack + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for one port's ack, drop its req, return latency and read word.
    task automatic wait_ack(input logic is_d, input int t0, output int lat, output logic [15:0] rd);
        logic got = 1'b0;
        int   n = 0;
        lat = -1;
        rd  = 16'h0;
        while (!got && n < 60) begin
            tick();
            n++;
            if (is_d ? m.dmem_ack : m.imem_ack) begin
                got = 1'b1;
                lat = cyc - t0;
                rd  = is_d ? m.dmem_rdata : m.imem_rdata;
                if (is_d) m.dmem_req = 1'b0; else m.imem_req = 1'b0;
            end
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    // Raise both reads together and serve until both acks are seen.
    task automatic run_pair(input logic [15:0] ia, input logic [15:0] da, output int t0,
                            output int dc, output int ic,
                            output logic [15:0] drd, output logic [15:0] ird);
        int n = 0;
        dc = -1; ic = -1; drd = '0; ird = '0;
        m.imem_addr = ia; m.dmem_addr = da; m.dmem_we = 1'b0;
        m.imem_req = 1'b1; m.dmem_req = 1'b1;
        t0 = cyc;
        while ((dc < 0 || ic < 0) && n < 80) begin
            tick();
            n++;
            if (m.dmem_ack) begin dc = cyc; drd = m.dmem_rdata; m.dmem_req = 1'b0; end
            if (m.imem_ack) begin ic = cyc; ird = m.imem_rdata; m.imem_req = 1'b0; end
        end
        if (dc < 0 || ic < 0) chk("pair_timeout", 32'd0, 32'd1);
    endtask

    // Single dmem read on the wrap instance; capture its go addresses.
    task automatic wrap_run(input logic [15:0] a, output logic [31:0] a0,
                            output logic [31:0] a1, output int ngo);
        logic got = 1'b0;
        int   n = 0;
        ngo = 0; a0 = '0; a1 = '0;
        w.dmem_addr = a; w.dmem_we = 1'b0; w.dmem_req = 1'b1;
        while (!got && n < 40) begin
            tick();
            n++;
            if (w.lpc_go) begin
                if (ngo == 0) a0 = w.lpc_addr; else a1 = w.lpc_addr;
                ngo++;
            end
            if (w.dmem_ack) begin got = 1'b1; w.dmem_req = 1'b0; end
        end
        if (!got) chk("wrap_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0, lat, g0, ia0, da0, dc, ic, ngo;
        logic [15:0] rd, drd, ird;
        logic [31:0] a0, a1;

        m.imem_req = 1'b0; m.imem_addr = '0;
        m.dmem_req = 1'b0; m.dmem_we = 1'b0; m.dmem_addr = '0; m.dmem_wdata = '0;
        w.imem_req = 1'b0; w.imem_addr = '0;
        w.dmem_req = 1'b0; w.dmem_we = 1'b0; w.dmem_addr = '0; w.dmem_wdata = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_acks",  {30'd0, m.imem_ack, m.dmem_ack}, 32'd0);
        chk("rst_rdata", {m.imem_rdata, m.dmem_rdata}, 32'd0);
        chk("rst_lpc",   {22'd0, m.lpc_go, m.lpc_dir, m.lpc_wdata}, 32'd0);
        chk("rst_addr",  m.lpc_addr, 32'd0);
        chk("rst_busy",  {31'd0, m.arb_busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Fetch of word 0x0010: bytes 0x20/0x21, ack in the 10th cycle
        // counting the request cycle as the first.
        g0 = go_addr.size(); ia0 = n_iack;
        rq = '{8'h34, 8'h12};
        m.imem_addr = 16'h0010; m.imem_req = 1'b1; t0 = cyc;
        wait_ack(1'b0, t0, lat, rd);
        chk("f_lat",   lat, 32'd9);
        chk("f_rdata", {16'd0, rd}, 32'h0000_1234);
        repeat (3) tick();
        chk("f_nack",  n_iack - ia0, 32'd1);
        chk("f_ngo",   go_addr.size() - g0, 32'd2);
        chk("f_addr0", go_addr[g0], 32'h0000_0020);
        chk("f_addr1", go_addr[g0+1], 32'h0000_0021);
        chk("f_dir",   {30'd0, go_dir[g0], go_dir[g0+1]}, 32'd0);
        chk("f_gocyc", go_cyc[g0+1] - go_cyc[g0], 32'd4);

        // Data read of word 4 -> 0x5AA5
        g0 = go_addr.size();
        rq = '{8'hA5, 8'h5A};
        m.dmem_addr = 16'h0004; m.dmem_we = 1'b0; m.dmem_req = 1'b1; t0 = cyc;
        wait_ack(1'b1, t0, lat, rd);
        chk("dr_rdata", {16'd0, rd}, 32'h0000_5AA5);
        chk("dr_addr0", go_addr[g0], 32'h0001_0008);
        chk("dr_addr1", go_addr[g0+1], 32'h0001_0009);

        // Data write of 0xBEEF to word 4
        tick();
        g0 = go_addr.size(); da0 = n_dack;
        m.dmem_addr = 16'h0004; m.dmem_wdata = 16'hBEEF; m.dmem_we = 1'b1; m.dmem_req = 1'b1; t0 = cyc;
        wait_ack(1'b1, t0, lat, rd);
        repeat (3) tick();
        chk("dw_ndack", n_dack - da0, 32'd1);
        chk("dw_ngo",   go_addr.size() - g0, 32'd2);
        chk("dw_go0",   {go_dir[g0], 23'd0, go_wd[g0]}, {1'b1, 23'd0, 8'hEF});
        chk("dw_go1",   {go_dir[g0+1], 23'd0, go_wd[g0+1]}, {1'b1, 23'd0, 8'hBE});
        chk("dw_addr0", go_addr[g0], 32'h0001_0008);
        chk("dw_addr1", go_addr[g0+1], 32'h0001_0009);
        chk("dw_rdata_hold", {16'd0, m.dmem_rdata}, 32'h0000_5AA5);
        m.dmem_we = 1'b0;

        // Stray done while idle is ignored
        ia0 = n_iack; da0 = n_dack;
        force_done = 1'b1; tick(); force_done = 1'b0; tick();
        chk("stray_done", {29'd0, m.arb_busy, m.imem_ack, m.dmem_ack}, 32'd0);

        // Simultaneous requests from reset: dmem first, imem granted after
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        g0 = go_addr.size();
        rq = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_pair(16'h0003, 16'h0002, t0, dc, ic, drd, ird);
        chk("pa_dlat",  dc - t0, 32'd9);
        chk("pa_igap",  ic - dc, 32'd10);
        chk("pa_drd",   {16'd0, drd}, 32'h0000_2211);
        chk("pa_ird",   {16'd0, ird}, 32'h0000_4433);
        chk("pa_daddr", go_addr[g0], 32'h0001_0004);
        chk("pa_iaddr", go_addr[g0+2], 32'h0000_0006);
        chk("pa_igo",   go_cyc[g0+2] - dc, 32'd2);

        // Lone data read, then a second simultaneous pair
        tick();
        rq = '{8'h01, 8'h02};
        m.dmem_addr = 16'h0005; m.dmem_req = 1'b1; t0 = cyc;
        wait_ack(1'b1, t0, lat, rd);
        chk("lone_rd", {16'd0, rd}, 32'h0000_0201);
        tick();
`ifdef LPC_ARB_RR_EN
        rq = '{8'h55, 8'h66, 8'h77, 8'h88};
        run_pair(16'h0007, 16'h0009, t0, dc, ic, drd, ird);
        chk("pb_ilat", ic - t0, 32'd9);
        chk("pb_dgap", dc - ic, 32'd10);
`else
        rq = '{8'h77, 8'h88, 8'h55, 8'h66};
        run_pair(16'h0007, 16'h0009, t0, dc, ic, drd, ird);
        chk("pb_dlat", dc - t0, 32'd9);
        chk("pb_igap", ic - dc, 32'd10);
`endif
        chk("pb_drd", {16'd0, drd}, 32'h0000_8877);
        chk("pb_ird", {16'd0, ird}, 32'h0000_6655);

        // Host busy for 5 cycles in ISSUE_LO
        tick();
        g0 = go_addr.size();
        rq = '{8'h9A, 8'hBC};
        force_busy = 1'b1;
        m.imem_addr = 16'h0100; m.imem_req = 1'b1; t0 = cyc;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy_nogo", {31'd0, m.lpc_go}, 32'd0);
        end
        chk("busy_arb", {31'd0, m.arb_busy}, 32'd1);
        tick();
        force_busy = 1'b0;
        wait_ack(1'b0, t0, lat, rd);
        chk("busy_lat",   lat, 32'd14);
        chk("busy_rd",    {16'd0, rd}, 32'h0000_BC9A);
        chk("busy_gocyc", go_cyc[g0] - t0, 32'd6);
        chk("busy_ngo",   go_addr.size() - g0, 32'd2);
        chk("busy_addr0", go_addr[g0], 32'h0000_0200);
        chk("busy_addr1", go_addr[g0+1], 32'h0000_0201);
        chk("stable",     stab_err, 32'd0);

        // Reset in WAIT_HI abandons the fetch
        tick();
        rq = '{8'hDE, 8'hAD};
        ia0 = n_iack;
        m.imem_addr = 16'h0020; m.imem_req = 1'b1; t0 = cyc;
        repeat (6) tick();
        chk("whi_addr", m.lpc_addr, 32'h0000_0041);
        rst_n = 1'b0; m.imem_req = 1'b0;
        tick();
        chk("mrst_out", {m.imem_ack, m.dmem_ack, m.lpc_go, m.lpc_dir, m.arb_busy, 19'd0, m.lpc_wdata}, 32'd0);
        chk("mrst_addr", m.lpc_addr, 32'd0);
        chk("mrst_rd",   {m.imem_rdata, m.dmem_rdata}, 32'd0);
        rst_n = 1'b1;
        rq.delete();
        repeat (6) tick();
        chk("mrst_noack", n_iack - ia0, 32'd0);
        rq = '{8'h0F, 8'hF0};
        m.dmem_addr = 16'h0008; m.dmem_we = 1'b0; m.dmem_req = 1'b1; t0 = cyc;
        wait_ack(1'b1, t0, lat, rd);
        chk("post_lat", lat, 32'd9);
        chk("post_rd",  {16'd0, rd}, 32'h0000_F00F);

        // Address wrap on the instance with DMEM_BASE = 0xFFFF_FFFE
        tick();
        wrap_run(16'h0000, a0, a1, ngo);
        chk("wrap0_ngo", ngo, 32'd2);
        chk("wrap0_a0",  a0, 32'hFFFF_FFFE);
        chk("wrap0_a1",  a1, 32'hFFFF_FFFF);
        tick();
        wrap_run(16'h0001, a0, a1, ngo);
        chk("wrap1_a0",  a0, 32'h0000_0000);
        chk("wrap1_a1",  a1, 32'h0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
